// File: rtl/data_memory_ctrl.sv
// Word-organised data RAM with a wait-state controller and a ready/fault handshake.
// Byte lanes are written selectively; out-of-range or conflicting requests complete with a fault.
module data_memory_ctrl #(
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data_out,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [3:0]  byte_enable,
  output logic [31:0] mem_data_in,
  output logic        mem_ready,
  output logic        mem_fault,
  output logic        busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [7:0] RdCnt = 8'(READ_LATENCY - 1);
  localparam logic [7:0] WrCnt = 8'(WRITE_LATENCY - 1);

  logic [1:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic                  range_q, range_d;
  logic                  fault_q, fault_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  mem_we;

  logic [31:0] mem [2**ADDR_WIDTH];

  // Lane selection comes from byte_enable, so the low address bits carry no information.
  logic unused_addr;
  assign unused_addr = ^mem_addr[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    range_d = range_q;
    fault_d = fault_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      StIdle: begin
        if (mem_read_en ^ mem_write_en) begin
          state_d = StWait;
          write_d = mem_write_en;
          idx_d   = mem_addr[ADDR_WIDTH+1:2];
          wdata_d = mem_data_out;
          be_d    = byte_enable;
          range_d = |mem_addr[31:ADDR_WIDTH+2];
          cnt_d   = mem_write_en ? WrCnt : RdCnt;
          fault_d = 1'b0;
        end else if (mem_read_en && mem_write_en) begin
          state_d = StDone;
          fault_d = 1'b1;
        end
      end
      StWait: begin
        if (cnt_q == 8'd0) begin
          // The array access happens on the edge that enters DONE.
          state_d = StDone;
          fault_d = range_q;
          if (!write_q) begin
            rdata_d = range_q ? 32'h0 : mem[idx_q];
          end else if (!range_q) begin
            mem_we = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      write_q <= 1'b0;
      range_q <= 1'b0;
      fault_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      range_q <= range_d;
      fault_q <= fault_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

  // Array contents survive reset; mem_we is only raised from WAIT, which reset leaves.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign mem_data_in = rdata_q;
  assign mem_ready   = (state_q == StDone);
  assign mem_fault   = (state_q == StDone) && fault_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: default-latency instance plus a WRITE_LATENCY=3 instance for the reset-abort case.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, rst3_n;
  logic [31:0] addr, wdata;
  logic        rd, wr;
  logic [3:0]  be;
  logic [31:0] data1, data3;
  logic        rdy1, flt1, busy1, rdy3, flt3, busy3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_memory_ctrl dut (
    .clk          (clk),
    .reset        (rst_n),
    .mem_addr     (addr),
    .mem_data_out (wdata),
    .mem_read_en  (rd),
    .mem_write_en (wr),
    .byte_enable  (be),
    .mem_data_in  (data1),
    .mem_ready    (rdy1),
    .mem_fault    (flt1),
    .busy         (busy1)
  );

  data_memory_ctrl #(
    .WRITE_LATENCY (3)
  ) dut_w3 (
    .clk          (clk),
    .reset        (rst3_n),
    .mem_addr     (addr),
    .mem_data_out (wdata),
    .mem_read_en  (rd),
    .mem_write_en (wr),
    .byte_enable  (be),
    .mem_data_in  (data3),
    .mem_ready    (rdy3),
    .mem_fault    (flt3),
    .busy         (busy3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one request, counts edges from presentation to the ready sample, then drops enables.
  task automatic access(input logic sel, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, output int n, output logic f);
    logic seen;
    seen = 1'b0;
    n = 0;
    f = 1'b0;
    @(posedge clk);
    #1;
    rd = r; wr = w; addr = a; wdata = d; be = b;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (sel ? rdy3 : rdy1) begin
        seen = 1'b1;
        f = sel ? flt3 : flt1;
      end
    end
    rd = 1'b0; wr = 1'b0;
    if (!seen) check("ready_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int   n, gap, busy_lo;
    logic f, seen;

    rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0;
    rst_n = 1'b0; rst3_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(rdy1), 32'd0);
    check("rst_fault", 32'(flt1), 32'd0);
    check("rst_busy",  32'(busy1), 32'd0);
    check("rst_data",  data1, 32'h0);
    rst_n = 1'b1; rst3_n = 1'b1;

    // Known word 0 for the out-of-range write check.
    access(1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0102_0304, 4'hf, n, f);

    // Full-word write then read.
    access(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'hf, n, f);
    check("wr_latency", 32'(n), 32'd2);
    check("wr_fault", 32'(f), 32'd0);
    access(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hf, n, f);
    check("rd_latency", 32'(n), 32'd3);
    check("rd_fault", 32'(f), 32'd0);
    check("rd_data", data1, 32'hAABB_CCDD);

    // Partial lane write, then an all-lanes-off write.
    access(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_EE00, 4'b0010, n, f);
    access(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hf, n, f);
    check("part_data", data1, 32'hAABB_EEDD);
    access(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0000, n, f);
    check("be0_fault", 32'(f), 32'd0);
    access(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hf, n, f);
    check("be0_data", data1, 32'hAABB_EEDD);

    // Out-of-range read and write.
    access(1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hf, n, f);
    check("oor_rd_latency", 32'(n), 32'd3);
    check("oor_rd_fault", 32'(f), 32'd1);
    check("oor_rd_data", data1, 32'h0);
    access(1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'h1111_1111, 4'hf, n, f);
    check("oor_wr_fault", 32'(f), 32'd1);
    access(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'hf, n, f);
    check("oor_word0", data1, 32'h0102_0304);

    // Both enables at once: fault, no access.
    access(1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h5555_5555, 4'hf, n, f);
    check("both_latency", 32'(n), 32'd1);
    check("both_fault", 32'(f), 32'd1);
    access(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hf, n, f);
    check("both_word", data1, 32'hAABB_EEDD);

    // Held read enable across two completions.
    @(posedge clk);
    #1;
    rd = 1'b1; addr = 32'h0000_0010; be = 4'hf;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rdy1;
    end
    if (!seen) check("held_first_timeout", 32'd0, 32'd1);
    gap = 0; busy_lo = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rdy1) seen = 1'b1;
      else begin
        gap++;
        if (!busy1) busy_lo++;
      end
    end
    rd = 1'b0;
    check("held_gap", 32'(gap), 32'd3);
    check("held_idle", 32'(busy_lo), 32'd1);
    check("held_data", data1, 32'hAABB_EEDD);

    // Reset during WAIT on the WRITE_LATENCY=3 instance drops the pending write.
    access(1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'hf, n, f);
    check("w3_latency", 32'(n), 32'd4);
    access(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'hf, n, f);
    check("w3_pre_data", data3, 32'hCAFE_F00D);
    @(posedge clk);
    #1;
    wr = 1'b1; addr = 32'h0000_0020; wdata = 32'h1234_5678; be = 4'hf;
    @(posedge clk);
    #1;
    wr = 1'b0;
    @(posedge clk);
    #1;
    check("w3_busy_wait", 32'(busy3), 32'd1);
    rst3_n = 1'b0;
    #1;
    check("w3_rst_busy", 32'(busy3), 32'd0);
    check("w3_rst_ready", 32'(rdy3), 32'd0);
    check("w3_rst_data", data3, 32'h0);
    #2;
    rst3_n = 1'b1;
    access(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'hf, n, f);
    check("w3_post_data", data3, 32'hCAFE_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Word-organised data RAM with a wait-state controller. Sits directly downstream of memory_interface: it consumes that block's mem_addr, mem_data_out, byte_enable, mem_read_en and mem_write_en, and returns mem_data_in. It adds a mem_ready/mem_fault handshake so the core can stall on multi-cycle accesses. Byte lanes are written selectively under byte_enable.

Parameters:
ADDR_WIDTH, 10, word-address bits; the array holds 2**ADDR_WIDTH 32-bit words (4 KiB default).
READ_LATENCY, 2, cycles from the accept edge to mem_ready on a read; must be >= 1.
WRITE_LATENCY, 1, cycles from the accept edge to mem_ready on a write; must be >= 1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
mem_addr  input  32  byte address; bits [1:0] are ignored (lane choice comes from byte_enable).
mem_data_out  input  32  write data, already lane-aligned upstream.
mem_read_en  input  1  read request; held high until mem_ready.
mem_write_en  input  1  write request; held high until mem_ready.
byte_enable  input  4  lane enables; bit i selects bits [8i+7:8i].
mem_data_in  output  32  read data, full word.
mem_ready  output  1  one-cycle completion pulse.
mem_fault  output  1  error flag, valid only while mem_ready is high.
busy  output  1  high while an access is in progress (state not IDLE).

Behaviour:
- Reset (reset low, asynchronous) forces:
  - state to IDLE;
  - mem_ready, mem_fault and busy to 0;
  - mem_data_in to 32'h0;
  - the latched request to be discarded, with no array write.
- Reset does not clear array contents.
- States and transitions:
  - IDLE: requests are sampled only here.
  - IDLE -> WAIT at the accept edge if exactly one of mem_read_en or mem_write_en is high.
  - At the accept edge, latch the request type, word index mem_addr[ADDR_WIDTH+1:2], mem_data_out, byte_enable and a range flag.
  - The range flag is set when mem_addr[31:ADDR_WIDTH+2] != 0.
  - Load the counter with the selected latency minus 1.
  - IDLE -> DONE with fault = 1 if both enables are high at the edge. Neither access is performed.
  - WAIT: the counter decrements each edge. When the counter is 0, the next edge goes to DONE.
  - DONE: lasts exactly one cycle, then returns to IDLE unconditionally.
- DONE-entry edge actions:
  - Read in range: mem_data_in is loaded with the array word.
  - Write in range: each lane with byte_enable[i] = 1 is written; the other lanes keep their values.
  - byte_enable = 0 on a write completes normally with no change to the array.
  - Out of range: no array access. A read sets mem_data_in to 0.
- mem_ready and mem_fault are 1 only during DONE.
- Latency: mem_ready is high during the cycle following edge E0+LAT, where E0 is the accept edge. READ_LATENCY=2 means ready is high in the third cycle after the request is presented.
- mem_data_in holds its value until the next completed read, reset, or fault read. Writes and idle cycles do not change it.
- Inputs that change after the accept edge are ignored, because the latched copy is used.
- An enable still high in the DONE cycle is treated as a new request. It is accepted at the first IDLE edge, so back-to-back accesses are separated by one IDLE cycle.
- Reset asserted during WAIT or DONE aborts the access; a pending write is lost.

Test Plan:
1. Full-word write, then read: write addr 0x00000010, data 0xAABBCCDD, be=1111 -> mem_ready is high 1 cycle after the accept edge. Then read 0x10 -> ready 2 cycles after accept, mem_data_in = 0xAABBCCDD, mem_fault = 0.
2. Partial write: over the word from test 1, write addr 0x10, data 0x0000EE00, be=0010 -> a subsequent read returns 0xAABBEEDD. Then write with be=0000 -> the read is still 0xAABBEEDD.
3. Out of range: read addr 0x00001000 (default ADDR_WIDTH) -> mem_ready = 1, mem_fault = 1, mem_data_in = 0. A write to the same address leaves word 0 unchanged.
4. Simultaneous enables: read_en = write_en = 1 at addr 0x10 -> fault pulse one cycle after the accept edge, word unchanged (0xAABBEEDD).
5. Reset mid-write: accept a write of 0x12345678 to addr 0x20 with WRITE_LATENCY=3, then pulse reset low during WAIT -> busy, ready and data go 0 immediately. A read of 0x20 afterwards returns the old contents, not 0x12345678.
6. Held enable: keep mem_read_en high across two completions -> ready pulses are separated by exactly READ_LATENCY+1 cycles, and busy drops to 0 for one cycle between accesses.
